// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/cmd/addr/wdata/ack slave port between N masters.
// Optional read-response watchdog is compiled in with `define ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_resp,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic                          s_resp,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          timeout_err,
  output logic [1:0]                    dbg_state
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int DB_WORDS = (DATA_W + 31) / 32;
  localparam logic [DB_WORDS*32-1:0] DB_FULL = {DB_WORDS{32'hDEADBEEF}};
  localparam logic [DATA_W-1:0] DB_DATA = DB_FULL[DATA_W-1:0];

  generate
    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("bus_rr_arbiter: N_MASTERS must be 2..8 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Handshake: a master holds m_req until its m_ack; the slave pulses s_ack
  // once while s_req is high, then (reads only) pulses s_resp at least one
  // cycle later. The owner keeps the grant until the whole transaction ends.

  state_t          state;
  logic [N_MASTERS-1:0] grant_q;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   own;
  logic [PW-1:0]   win;
  logic            wd_fire;

  assign grant     = grant_q;
  assign dbg_state = state;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (!found && m_req[(int'(ptr) + k) % N_MASTERS]) begin
        win   = PW'((int'(ptr) + k) % N_MASTERS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_cmd   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    case (state)
      S_REQ: begin
        s_req   = m_req[own];
        s_cmd   = m_cmd[own];
        s_addr  = m_addr[int'(own)*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[int'(own)*DATA_W +: DATA_W];
        m_ack[own] = s_ack & m_req[own];
      end
      S_WAIT: begin
        if (s_resp) begin
          m_resp[own] = 1'b1;
          m_rdata     = s_rdata;
        end else if (wd_fire) begin
          m_resp[own] = 1'b1;
          m_rdata     = DB_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      grant_q <= '0;
      ptr     <= PW'(N_MASTERS - 1);
      own     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|m_req) begin
            grant_q <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win;
            ptr     <= win;
            own     <= win;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An abandoned request takes priority over a coincident ack.
          if (!m_req[own]) begin
            state   <= S_IDLE;
            grant_q <= '0;
          end else if (s_ack) begin
            if (m_cmd[own]) begin
              state   <= S_IDLE;
              grant_q <= '0;
            end else begin
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (s_resp || wd_fire) begin
            state   <= S_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            terr_q;

  assign wd_fire     = (state == S_WAIT) && (wd == WD_W'(TIMEOUT));
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd     <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state == S_REQ && s_ack && m_req[own] && !m_cmd[own]) begin
        wd <= '0;
      end else if (state == S_WAIT && !wd_fire) begin
        wd <= wd + WD_W'(1);
      end
      // A real response in the firing cycle wins over the timeout.
      if (wd_fire && !s_resp) begin
        terr_q <= 1'b1;
      end
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_bus_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_cmd = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_resp;
  logic [DW-1:0]   m_rdata;
  logic            s_req;
  logic            s_cmd;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack = 1'b0;
  logic            s_resp = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic [N-1:0]    grant;
  logic            timeout_err;
  logic [1:0]      dbg_state;

  bus_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ack_cnt[N];
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // owner = -1 when idle; phase 0 idle, 1 request outstanding, 2 awaiting read data
  int m_own = -1;
  int m_ptr = N - 1;
  int m_ph  = 0;
  int m_wd  = 0;
  bit m_terr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own = -1; m_ptr = N - 1; m_ph = 0; m_wd = 0; m_terr = 1'b0;
    end else begin
      case (m_ph)
        0: if (m_req != '0) begin
             for (int k = 1; k <= N; k++) begin
               if (m_req[(m_ptr + k) % N]) begin
                 m_own = (m_ptr + k) % N;
                 break;
               end
             end
             m_ptr = m_own;
             m_ph  = 1;
           end
        1: if (!m_req[m_own]) begin
             m_ph = 0; m_own = -1;
           end else if (s_ack) begin
             if (m_cmd[m_own]) begin m_ph = 0; m_own = -1; end
             else begin m_ph = 2; m_wd = 0; end
           end
        default: if (s_resp) begin
             m_ph = 0; m_own = -1;
           end else if (TO_ON && m_wd == TO) begin
             m_terr = 1'b1; m_ph = 0; m_own = -1;
           end else begin
             m_wd++;
           end
      endcase
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0]  e_grant, e_ack, e_resp;
      logic          e_sreq, e_scmd, to;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_rdata;
      e_grant = (m_ph != 0) ? N'(1 << m_own) : '0;
      e_sreq  = (m_ph == 1) && m_req[m_own];
      e_scmd  = (m_ph == 1) ? m_cmd[m_own] : 1'b0;
      e_addr  = (m_ph == 1) ? m_addr[m_own*AW +: AW] : '0;
      e_wdata = (m_ph == 1) ? m_wdata[m_own*DW +: DW] : '0;
      e_ack   = (m_ph == 1 && m_req[m_own] && s_ack) ? N'(1 << m_own) : '0;
      to      = (m_ph == 2) && TO_ON && (m_wd == TO) && !s_resp;
      e_resp  = (m_ph == 2 && (s_resp || to)) ? N'(1 << m_own) : '0;
      e_rdata = (m_ph == 2 && s_resp) ? s_rdata : (to ? 32'hDEADBEEF : '0);
      chk("sb grant", grant, e_grant);
      chk("sb s_req", s_req, e_sreq);
      chk("sb s_cmd", s_cmd, e_scmd);
      chk("sb s_addr", s_addr, e_addr);
      chk("sb s_wdata", s_wdata, e_wdata);
      chk("sb m_ack", m_ack, e_ack);
      chk("sb m_resp", m_resp, e_resp);
      chk("sb m_rdata", m_rdata, e_rdata);
      chk("sb timeout_err", timeout_err, m_terr);
    end
    for (int i = 0; i < N; i++) if (m_ack[i]) ack_cnt[i]++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset grant", grant, 0);
    chk("reset s_req", s_req, 0);
    chk("reset state", dbg_state, 0);
    chk("reset timeout_err", timeout_err, 0);
    tick();
    rst = 1'b1;

    // single write, master 0
    m_req = 2'b01; m_cmd = 2'b01;
    m_addr[0 +: AW] = 32'h10; m_wdata[0 +: DW] = 32'hA5A5A5A5;
    @(negedge clk); chk("wr s_req latency", s_req, 0);
    tick();
    @(negedge clk);
    chk("wr s_req", s_req, 1); chk("wr grant", grant, 2'b01);
    chk("wr s_addr", s_addr, 32'h10); chk("wr s_wdata", s_wdata, 32'hA5A5A5A5);
    tick(); @(negedge clk); chk("wr no early ack", m_ack, 0);
    tick(); s_ack = 1'b1;
    @(negedge clk); chk("wr m_ack", m_ack, 2'b01);
    tick(); s_ack = 1'b0; m_req = '0;
    @(negedge clk); chk("wr grant released", grant, 0);

    // single read, master 1
    tick();
    m_req = 2'b10; m_cmd = 2'b00; m_addr[AW +: AW] = 32'h20;
    tick(); @(negedge clk);
    chk("rd grant", grant, 2'b10); chk("rd s_cmd", s_cmd, 0); chk("rd s_addr", s_addr, 32'h20);
    tick(); s_ack = 1'b1;
    @(negedge clk); chk("rd m_ack", m_ack, 2'b10);
    tick(); s_ack = 1'b0; m_req = '0;
    @(negedge clk); chk("rd wait s_req", s_req, 0); chk("rd wait grant", grant, 2'b10);
    tick(); @(negedge clk); chk("rd wait s_req2", s_req, 0);
    tick(); s_resp = 1'b1; s_rdata = 32'h12345678;
    @(negedge clk); chk("rd m_resp", m_resp, 2'b10); chk("rd m_rdata", m_rdata, 32'h12345678);
    tick(); s_resp = 1'b0; s_rdata = '0;
    @(negedge clk); chk("rd grant released", grant, 0); chk("rd rdata idle", m_rdata, 0);

    // stray strobes in idle
    tick(); s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("stray m_ack", m_ack, 0); chk("stray m_resp", m_resp, 0); chk("stray m_rdata", m_rdata, 0);
    tick(); s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;

    // contention fairness from reset
    rst = 1'b0;
    tick(); rst = 1'b1;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    m_req = 2'b11; m_cmd = 2'b11;
    m_wdata[0 +: DW] = 32'h0000AAAA; m_wdata[DW +: DW] = 32'h0000BBBB;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (grant == '0 && w < 8) begin tick(); w++; end
      chk("rr wait expired", (w >= 8), 0);
      chk("rr grant order", grant, (t % 2) ? 2'b10 : 2'b01);
      s_ack = 1'b1;
      tick(); s_ack = 1'b0;
    end
    m_req = '0;
    tick(); tick();
    chk("rr acks m0", ack_cnt[0], 2);
    chk("rr acks m1", ack_cnt[1], 2);

    // abandoned request: master 0 drops before ack, master 1 pending
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    m_req = 2'b11; m_cmd = 2'b10;
    tick(); chk("ab grant m0", grant, 2'b01);
    m_req = 2'b10;
    @(negedge clk); chk("ab s_req low", s_req, 0); chk("ab no ack", m_ack, 0);
    tick(); chk("ab back to idle", grant, 0);
    tick(); chk("ab grant m1", grant, 2'b10);
    s_ack = 1'b1;
    @(negedge clk); chk("ab m1 ack", m_ack, 2'b10);
    tick(); s_ack = 1'b0; m_req = '0;
    chk("ab m0 never acked", ack_cnt[0], 0);

    // reset during read wait
    tick();
    m_req = 2'b01; m_cmd = 2'b00; m_addr[0 +: AW] = 32'h30;
    tick(); s_ack = 1'b1;
    tick(); s_ack = 1'b0; m_req = '0;
    chk("rst-rd in wait", grant, 2'b01);
    #2 rst = 1'b0;
    #1;
    chk("rst-rd grant", grant, 0); chk("rst-rd s_req", s_req, 0);
    chk("rst-rd m_resp", m_resp, 0); chk("rst-rd state", dbg_state, 0);
    tick(); rst = 1'b1; s_resp = 1'b1; s_rdata = 32'h0000CAFE;
    @(negedge clk); chk("rst-rd late resp", m_resp, 0); chk("rst-rd late rdata", m_rdata, 0);
    tick(); s_resp = 1'b0; s_rdata = '0;

    // long read wait (watchdog fires only when compiled in)
    m_req = 2'b10; m_cmd = 2'b00; m_addr[AW +: AW] = 32'h40;
    tick(); s_ack = 1'b1;
    tick(); s_ack = 1'b0; m_req = '0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk("wd quiet", m_resp, 0);
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    @(negedge clk);
    chk("wd m_resp", m_resp, 2'b10); chk("wd m_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    chk("wd err set", timeout_err, 1); chk("wd grant released", grant, 0);
`else
    @(negedge clk); chk("wait still held", grant, 2'b10);
    tick(); s_resp = 1'b1; s_rdata = 32'h5A5A5A5A;
    @(negedge clk); chk("late m_resp", m_resp, 2'b10); chk("late m_rdata", m_rdata, 32'h5A5A5A5A);
    tick(); s_resp = 1'b0; s_rdata = '0;
    chk("late grant released", grant, 0); chk("no err flag", timeout_err, 0);
`endif

    // next request served normally
    m_req = 2'b01; m_cmd = 2'b01; m_wdata[0 +: DW] = 32'h0BADF00D;
    tick(); chk("post grant", grant, 2'b01);
    s_ack = 1'b1;
    @(negedge clk); chk("post m_ack", m_ack, 2'b01); chk("post s_wdata", s_wdata, 32'h0BADF00D);
    tick(); s_ack = 1'b0; m_req = '0;
    tick();
    chk("post err sticky", timeout_err, TO_ON);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
